// File: rtl/game_pkg.sv
// Shared types, geometry constants and helpers for the pipe game controller.
// Positions are 12-bit signed screen x; pipe words pack {0, addr, height}.
package game_pkg;

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_e;

    localparam int NUM_PIPES = 3;

    localparam logic signed [11:0] PARK_X   = 12'sd700;
    localparam logic signed [11:0] SCREEN_W = 12'sd640;
    localparam logic signed [11:0] PIPE_W   = 12'sd50;
    localparam logic signed [11:0] BIRD_X   = 12'sd10;
    localparam logic signed [11:0] BIRD_W   = 12'sd16;
    localparam logic signed [11:0] PASS_X   = -12'sd39;
    localparam logic signed [11:0] RETIRE_X = -12'sd50;

    localparam int H_LSB   = 0;
    localparam int X_LSB   = 10;
    localparam int FIELD_W = 10;

    // Off-screen positions map to PARK_X; negatives wrap to 975..1023 on purpose.
    function automatic logic [31:0] pipe_word(logic signed [11:0] x, logic [9:0] h);
        logic [31:0] w;
        logic [9:0]  a;
        if (x >= -(PIPE_W - 12'sd1) && x <= SCREEN_W - 12'sd1) a = x[9:0];
        else                                                   a = PARK_X[9:0];
        w = '0;
        w[X_LSB +: FIELD_W] = a;
        w[H_LSB +: FIELD_W] = h;
        return w;
    endfunction

    function automatic logic [15:0] bcd_inc(logic [15:0] s);
        logic [15:0] r;
        logic        done;
        r    = s;
        done = (s == 16'h9999);
        for (int i = 0; i < 4; i++) begin
            if (!done) begin
                if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    done = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Each starting pipe gets a differently scrambled view of the same LFSR value.
    function automatic logic [6:0] spawn_bits(logic [7:0] l, int idx);
        logic [7:0] m;
        case (idx)
            0:       m = l;
            1:       m = {l[3:0], l[7:4]};
            default: m = l ^ 8'h3C;
        endcase
        return m[6:0];
    endfunction

endpackage

// File: rtl/pipe_scheduler_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), stepping when en is high.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst)     q <= SEED;
        else if (en) q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end

endmodule

// File: rtl/pipe_scheduler.sv
// Game-flow controller: state machine, pipe scrolling/respawn and BCD score.
// All outputs come straight from registers.
module pipe_scheduler import game_pkg::*; #(
    parameter int         SPEED     = 2,
    parameter int         SPACING   = 240,
    parameter int         H_MIN     = 100,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        fail,
    output logic [31:0] pipe_1,
    output logic [31:0] pipe_2,
    output logic [31:0] pipe_3,
    output logic [15:0] score,
    output logic        running
);

    localparam logic signed [11:0] SPEED_X   = 12'(SPEED);
    localparam logic signed [11:0] RESPAWN_D = 12'(3 * SPACING);

    state_e             state_q;
    logic               running_q;
    logic [15:0]        score_q, score_d;
    logic [7:0]         lfsr;
    logic signed [11:0] xpos_q   [NUM_PIPES];
    logic signed [11:0] xpos_d   [NUM_PIPES];
    logic signed [11:0] xmove    [NUM_PIPES];
    logic [9:0]         height_q [NUM_PIPES];
    logic [9:0]         height_d [NUM_PIPES];
    logic [31:0]        word_q   [NUM_PIPES];
    logic [NUM_PIPES-1:0] pass, retire;
    logic               go, step;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (frame_tick),
        .q   (lfsr)
    );

    // fail has priority over frame_tick: a losing frame never scrolls or scores
    assign go   = (state_q != RUN) && start;
    assign step = (state_q == RUN) && frame_tick && !fail;

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
        assign xmove[g]  = xpos_q[g] - SPEED_X;
        assign pass[g]   = (xpos_q[g] >= PASS_X) && (xmove[g] < PASS_X);
        assign retire[g] = (xmove[g] <= RETIRE_X);

        assign xpos_d[g] = go   ? SCREEN_W + 12'(g * SPACING) :
                           step ? (retire[g] ? xmove[g] + RESPAWN_D : xmove[g]) :
                                  xpos_q[g];

        assign height_d[g] = go ? 10'(H_MIN) + {3'b0, spawn_bits(lfsr, g)} :
                             (step && retire[g]) ? 10'(H_MIN) + {3'b0, lfsr[6:0]} :
                             height_q[g];
    end

    always_comb begin
        score_d = score_q;
        if (go) score_d = '0;
        else if (step) begin
            for (int i = 0; i < NUM_PIPES; i++)
                if (pass[i]) score_d = bcd_inc(score_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            score_q   <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                xpos_q[i]   <= PARK_X;
                height_q[i] <= '0;
                word_q[i]   <= pipe_word(PARK_X, 10'd0);
            end
        end else begin
            score_q <= score_d;
            for (int i = 0; i < NUM_PIPES; i++) begin
                xpos_q[i]   <= xpos_d[i];
                height_q[i] <= height_d[i];
                word_q[i]   <= pipe_word(xpos_d[i], height_d[i]);
            end
            case (state_q)
                IDLE, OVER: if (start) begin
                    state_q   <= RUN;
                    running_q <= 1'b1;
                end
                RUN: if (fail) begin
                    state_q   <= OVER;
                    running_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign pipe_1  = word_q[0];
    assign pipe_2  = word_q[1];
    assign pipe_3  = word_q[2];
    assign score   = score_q;
    assign running = running_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed + random stimulus against a behavioural game model (integers, decimal score).
module tb_pipe_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        fail = 1'b0;
    logic [31:0] pipe_1, pipe_2, pipe_3;
    logic [15:0] score;
    logic        running;

    int n_vec = 0;
    int n_err = 0;

    // model state: 0 idle, 1 run, 2 over
    int mst, msc, mlf;
    int mx[3];
    int mh[3];

    pipe_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .fail       (fail),
        .pipe_1     (pipe_1),
        .pipe_2     (pipe_2),
        .pipe_3     (pipe_3),
        .score      (score),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h @%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_word(int i);
        int a;
        if (mx[i] >= -49 && mx[i] <= 639) a = (mx[i] < 0) ? mx[i] + 1024 : mx[i];
        else a = 700;
        return 32'(a * 1024 + mh[i]);
    endfunction

    function automatic logic [31:0] exp_bcd();
        return 32'((msc / 1000) * 4096 + ((msc / 100) % 10) * 256 + ((msc / 10) % 10) * 16 + msc % 10);
    endfunction

    task automatic model_step(input bit r, input bit tk, input bit st, input bit fl);
        int l, n, rot;
        if (r) begin
            mst = 0; msc = 0; mlf = 'hA5;
            for (int i = 0; i < 3; i++) begin mx[i] = 700; mh[i] = 0; end
            return;
        end
        l = mlf;
        if (mst != 1 && st) begin
            mst = 1; msc = 0;
            rot = (l % 16) * 16 + l / 16;
            for (int i = 0; i < 3; i++) mx[i] = 640 + 240 * i;
            mh[0] = 100 + l % 128;
            mh[1] = 100 + rot % 128;
            mh[2] = 100 + (l ^ 60) % 128;
        end else if (mst == 1) begin
            if (fl) mst = 2;
            else if (tk) begin
                for (int i = 0; i < 3; i++) begin
                    n = mx[i] - 2;
                    if (mx[i] >= -39 && n < -39 && msc < 9999) msc++;
                    if (n <= -50) begin
                        n += 720;
                        mh[i] = 100 + l % 128;
                    end
                    mx[i] = n;
                end
            end
        end
        if (tk) mlf = ((mlf << 1) & 255) | (((mlf >> 7) ^ (mlf >> 5) ^ (mlf >> 4) ^ (mlf >> 3)) & 1);
    endtask

    task automatic cycle(input bit tk, input bit st, input bit fl, input bit r);
        frame_tick = tk; start = st; fail = fl; rst = r;
        @(posedge clk);
        model_step(r, tk, st, fl);
        #1;
        chk("pipe_1", pipe_1, exp_word(0));
        chk("pipe_2", pipe_2, exp_word(1));
        chk("pipe_3", pipe_3, exp_word(2));
        chk("score", {16'h0, score}, exp_bcd());
        chk("running", {31'h0, running}, {31'h0, mst == 1});
    endtask

    initial begin
        model_step(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        chk("rst_word", pipe_1, {12'h0, 10'd700, 10'd0});

        // start from reset: heights derive from seed A5
        cycle(0, 1, 0, 0);
        chk("init_p1", pipe_1, {12'h0, 10'd700, 10'd137});
        chk("init_p2", pipe_2, {12'h0, 10'd700, 10'd190});
        chk("init_p3", pipe_3, {12'h0, 10'd700, 10'd125});
        chk("init_run", {31'h0, running}, 32'd1);

        cycle(1, 0, 0, 0);
        chk("t1_p1", 32'(pipe_1[19:10]), 32'd638);
        chk("t1_p2", 32'(pipe_2[19:10]), 32'd700);
        repeat (339) cycle(1, 0, 0, 0);
        chk("t340_p1", 32'(pipe_1[19:10]), 32'd984);
        chk("t340_sc", {16'h0, score}, 32'h0001);
        repeat (5) cycle(1, 0, 0, 0);
        chk("t345_p1", 32'(pipe_1[19:10]), 32'd700);
        chk("t345_p2", 32'(pipe_2[19:10]), 32'd190);

        // fail together with tick, then OVER ignores ticks and fail
        cycle(1, 0, 1, 0);
        chk("over_run", {31'h0, running}, 32'd0);
        repeat (5) cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        chk("restart_sc", {16'h0, score}, 32'h0);

        // score saturation from a preloaded 9998
        msc = 9998;
        force dut.score_q = 16'h9998;
        cycle(0, 0, 0, 0);
        release dut.score_q;
        repeat (600) cycle(1, 0, 0, 0);
        chk("sat_sc", {16'h0, score}, 32'h9999);

        // start in RUN ignored, then reset mid-game
        repeat (37) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 1);
        chk("mrst_p1", pipe_1, {12'h0, 10'd700, 10'd0});
        chk("mrst_sc", {16'h0, score}, 32'h0);
        chk("mrst_run", {31'h0, running}, 32'd0);
        cycle(0, 1, 0, 0);
        chk("mrst_h1", pipe_1, {12'h0, 10'd700, 10'd137});
        chk("mrst_h3", pipe_3, {12'h0, 10'd700, 10'd125});

        for (int k = 0; k < 4000; k++)
            cycle(1'($urandom_range(0, 1)),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 799) == 0,
                  $urandom_range(0, 999) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_scheduler.md
Name: pipe_scheduler

Overview:
- Game-flow controller that sequences the three pipe groups consumed by the display block.
- Owns the game state, per-frame scrolling, respawn with pseudo-random heights, and the BCD score shown on the 7-segment display.
- Sits between the frame-tick source (VGA vsync edge) and the display; all outputs are registered.

Parameters:
- SPEED, 2, pixels each pipe moves left per frame_tick.
- SPACING, 240, horizontal distance between consecutive pipe groups.
- H_MIN, 100, minimum pipe height; height = H_MIN + lfsr[6:0].
- LFSR_SEED, 8'hA5, LFSR value after reset.

Ports:
- clk  in  1  system clock, the same clock as the display.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  one-cycle pulse from the game input; begins or restarts a game.
- fail  in  1  level or pulse from collision logic.
- pipe_1, pipe_2, pipe_3  out  32 each  pipe word: [9:0] height, [19:10] x address, [31:20] = 0.
- score  out  16  four BCD digits.
- running  out  1  high in state RUN.

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst; clock port is clk.
- Reset values:
  - State IDLE.
  - All pipe words {12'h0, 10'd700 (PARK), 10'd0}.
  - score 16'h0000, running 0, lfsr LFSR_SEED.
- Internal position: each pipe holds a 12-bit signed xpos.
- Output address:
  - Equals xpos[9:0] when -49 <= xpos <= 639.
  - Otherwise PARK = 700. PARK is never rendered for any x in 0..639.
  - Negative xpos wraps to 975..1023, which the display renders as partial left-edge visibility. This mapping is intentional.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Each step shifts left and inserts b7^b5^b4^b3 at bit 0. It steps once per frame_tick in every state (not in reset).
- IDLE:
  - Pipes parked; score holds its last value.
  - start goes to RUN.
- IDLE/OVER to RUN transition on start, applied the next cycle:
  - score = 0.
  - xpos = 640, 880, 1120.
  - Heights = H_MIN + L[6:0], H_MIN + rot4(L)[6:0], H_MIN + (L^8'h3C)[6:0], where L is the current lfsr.
- RUN, on frame_tick (results visible the next cycle):
  - Each xpos decreases by SPEED.
  - Pass: if old xpos >= -39 and new xpos < -39, the score BCD-increments once per pipe (the bird occupies x 10..25). Saturate at 9999. Two passes on one tick add 2.
  - Retire: if new xpos <= -50, xpos += 3*SPACING and height = H_MIN + lfsr[6:0] (pre-step lfsr value).
- RUN with fail high: go to OVER. Positions freeze and running = 0.
- fail and frame_tick in the same cycle: fail wins, no movement, no score change.
- OVER:
  - Pipes and score hold.
  - start goes to RUN (restart).
  - fail is ignored.
- start in RUN is ignored. start and fail in the same cycle in RUN gives OVER.
- rst at any time: IDLE with reset values on the next edge.
- Width rules:
  - xpos arithmetic is 12-bit signed.
  - Height sum is 10-bit; it cannot overflow (max 227).
  - Bottom-pipe gap is fixed by the display as 579 - 2*height, giving a range of 125..379.

Decomposition:
- Shared package (game_pkg):
  - State enum IDLE/RUN/OVER.
  - Constants PARK_X=700, SCREEN_W=640, PIPE_W=50, BIRD_X=10, BIRD_W=16, PASS_X=-39, RETIRE_X=-50.
  - Pipe-word field offsets.
- One sub-module: lfsr8 (clk, rst, en, seed parameter, q[7:0]).
- Per-pipe update logic is replicated by a generate loop, not a sub-module.

Test Plan:
- Reset then start with no prior tick (L=A5):
  - Next cycle, heights are 137, 190, 125.
  - pipe_1[19:10]=700, since xpos 640 is above 639 and parked.
  - score=0000, running=1.
- One frame_tick after start: pipe_1 addr=638, pipe_2 addr=700, pipe_3 addr=700. LFSR becomes 8'h4A.
- 340 ticks after start:
  - pipe_1 xpos -40, so addr=984 and score=0001.
  - At 345 ticks, pipe_1 xpos -50 respawns at 670 (addr 700) with a new height, and pipe_2 addr=190.
- fail asserted in the same cycle as frame_tick in RUN:
  - State OVER, pipe words unchanged, running=0.
  - Later ticks change nothing; start restarts with score=0000.
- Score preloaded by running to 9999 (force or long sim), then one more pass: score stays 9999.
- Assert rst mid-RUN at an arbitrary tick: next cycle all addrs=700, score=0000, lfsr=A5, state IDLE. start in RUN before that is ignored.
